// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings,
// FSM state codes and the default word length.
package muldiv_pkg;

  localparam int MD_WL = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef logic [1:0] md_state_t;

  localparam md_state_t ST_IDLE  = 2'd0;
  localparam md_state_t ST_CALC  = 2'd1;
  localparam md_state_t ST_FIXUP = 2'd2;
  localparam md_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WL = MD_WL
) ();

  logic          start;
  logic [1:0]    op;
  logic [WL-1:0] a;
  logic [WL-1:0] b;
  logic          busy;
  logic          done;
  logic [WL-1:0] hi;
  logic [WL-1:0] lo;
  logic          div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_addsub.sv
// Combinational add/subtract with carry (add) or borrow (subtract) out,
// shared by the shift-add multiply and restoring divide iterations.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] res_o,
  output logic         cout_o
);

  logic [W:0] sum_s;

  // Single adder; cout_o is the borrow when subtracting.
  always_comb begin
    if (sub_i) begin
      sum_s = {1'b0, x_i} - {1'b0, y_i};
    end else begin
      sum_s = {1'b0, x_i} + {1'b0, y_i};
    end
  end

  assign {cout_o, res_o} = sum_s;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO result registers
// and a start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WL = MD_WL
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WL);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WL:0]     hacc_q, hacc_d;
  logic [WL-1:0]   lacc_q, lacc_d;
  logic [WL-1:0]   mcand_q, mcand_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic            zdiv_q, zdiv_d, hold_q, hold_d;
  logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WL-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic            is_div_s, a_neg_s, b_neg_s, zero_b_s;
  logic [WL-1:0]   a_mag_s, b_mag_s;
  logic [WL:0]     as_x_s, as_y_s, as_res_s;
  logic            as_sub_s, as_cout_s;
  logic [2*WL-1:0] prod_s;
  logic [WL-1:0]   quo_s, rem_s;

  assign is_div_s = bus.op[1];
  assign a_neg_s  = ~bus.op[0] & bus.a[WL-1];
  assign b_neg_s  = ~bus.op[0] & bus.b[WL-1];
  assign a_mag_s  = a_neg_s ? -bus.a : bus.a;
  assign b_mag_s  = b_neg_s ? -bus.b : bus.b;
  assign zero_b_s = (bus.b == {WL{1'b0}});

  // Operand selection for the shared adder: subtract trial for divide, conditional add for multiply.
  always_comb begin
    if (op_q[1]) begin
      as_x_s   = {hacc_q[WL-1:0], lacc_q[WL-1]};
      as_y_s   = {1'b0, mcand_q};
      as_sub_s = 1'b1;
    end else begin
      as_x_s   = {1'b0, hacc_q[WL-1:0]};
      as_y_s   = lacc_q[0] ? {1'b0, mcand_q} : {(WL+1){1'b0}};
      as_sub_s = 1'b0;
    end
  end

  muldiv_addsub #(.W(WL+1)) u_addsub (
    .x_i    (as_x_s),
    .y_i    (as_y_s),
    .sub_i  (as_sub_s),
    .res_o  (as_res_s),
    .cout_o (as_cout_s)
  );

  assign prod_s = neg_q  ? -{hacc_q[WL-1:0], lacc_q} : {hacc_q[WL-1:0], lacc_q};
  assign quo_s  = neg_q  ? -lacc_q : lacc_q;
  assign rem_s  = rneg_q ? -hacc_q[WL-1:0] : hacc_q[WL-1:0];

  // FSM next state, iteration datapath and result writeback.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hacc_d  = hacc_q;
    lacc_d  = lacc_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    zdiv_d  = zdiv_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d    = bus.op;
          neg_d   = a_neg_s ^ b_neg_s;
          rneg_d  = a_neg_s;
          cnt_d   = CW'(WL-1);
          busy_d  = 1'b1;
          hacc_d  = {(WL+1){1'b0}};
          zdiv_d  = is_div_s & zero_b_s;
          hold_d  = is_div_s & zero_b_s;
          mcand_d = is_div_s ? b_mag_s : a_mag_s;
          if (is_div_s & zero_b_s) begin
            lacc_d  = bus.a;
            state_d = ST_FIXUP;
          end else begin
            lacc_d  = is_div_s ? a_mag_s : b_mag_s;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (op_q[1]) begin
          hacc_d = as_cout_s ? as_x_s : as_res_s;
          lacc_d = {lacc_q[WL-2:0], ~as_cout_s};
        end else begin
          hacc_d = {1'b0, as_res_s[WL:1]};
          lacc_d = {as_res_s[0], lacc_q[WL-1:1]};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIXUP: begin
        // A zero divisor skips CALC but still spends one settle cycle here.
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (zdiv_q) begin
            hi_d  = lacc_q;
            lo_d  = {WL{1'b1}};
            dbz_d = 1'b1;
          end else if (op_q[1]) begin
            hi_d  = rem_s;
            lo_d  = quo_s;
            dbz_d = 1'b0;
          end else begin
            hi_d  = prod_s[2*WL-1:WL];
            lo_d  = prod_s[WL-1:0];
            dbz_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      hacc_q  <= {(WL+1){1'b0}};
      lacc_q  <= {WL{1'b0}};
      mcand_q <= {WL{1'b0}};
      op_q    <= 2'b00;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= {WL{1'b0}};
      lo_q    <= {WL{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hacc_q  <= hacc_d;
      lacc_q  <= lacc_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      zdiv_q  <= zdiv_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, flag, ignored
// start, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_if #(.WL(32)) bus ();

  muldiv_unit #(.WL(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Drive a request now; return #1 after the edge that samples it, operands scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.a     = ~av;
    bus.b     = 32'h0000_0000;
  endtask

  // Called #1 after the accepting edge; optionally pulses start at edge T+poke.
  task automatic wait_done(input string tag, input int lat, input int poke,
                           input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int k;
    bit busy_bad;
    k = 0;
    busy_bad = 1'b0;
    while (!bus.done && k < lat + 5) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (k == poke - 1) begin
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'h0000_0005;
        bus.b     = 32'h0000_0007;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    bus.start = 1'b0;
    check_eq({tag, "_latency"}, 64'(k), 64'(lat));
    check_eq({tag, "_busy_during"}, {63'd0, busy_bad}, 64'd0);
    check_eq({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    check_eq({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
    check_eq({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
    check_eq({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, ed});
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input int lat, input int poke,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
    @(negedge clk);
    launch(o, av, bv);
    wait_done(tag, lat, poke, eh, el, ed);
  endtask

  initial begin
    int done_cnt;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0000_0000;
    bus.b     = 32'h0000_0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("reset_done", {63'd0, bus.done}, 64'd0);
    check_eq("reset_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("reset_lo", {32'd0, bus.lo}, 64'd0);
    check_eq("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);

    do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op("mult_m3x5", MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op("div_m7d2",  MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("div_7dm2",  MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 33, 0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    do_op("divu_by0",  MD_DIVU,  32'h0000_0064, 32'h0000_0000, 2,  0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    do_op("multu_2x3", MD_MULTU, 32'h0000_0002, 32'h0000_0003, 33, 0, 32'h0000_0000, 32'h0000_0006, 1'b0);
    do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 0, 32'h0000_0000, 32'h8000_0000, 1'b0);
    do_op("divu_poke", MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 33, 5, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

    // Back-to-back: second request held high during the first op's done cycle.
    do_op("b2b_first", MD_MULT,  32'h0000_0007, 32'hFFFF_FFFA, 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
    launch(MD_DIVU, 32'h0000_03E8, 32'h0000_0007);
    check_eq("b2b_hold_hi", {32'd0, bus.hi}, {32'd0, 32'hFFFF_FFFF});
    check_eq("b2b_hold_lo", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFD6});
    wait_done("b2b_second", 33, 0, 32'h0000_0006, 32'h0000_008E, 1'b0);

    // Reset in the middle of a divide.
    @(negedge clk);
    launch(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_mid_done", {63'd0, bus.done}, 64'd0);
    check_eq("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
    check_eq("rst_mid_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    check_eq("rst_no_done", 64'(done_cnt), 64'd0);
    do_op("after_rst", MD_MULTU, 32'h0000_0002, 32'h0000_0003, 33, 0, 32'h0000_0000, 32'h0000_0006, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative radix-2 multiply/divide unit for the MIPS datapath, implementing MULT, MULTU, DIV and DIVU with HI/LO result registers. It sits beside the combinational ALU and is the multi-cycle path the control unit uses for operations the ALU does not provide. Operands and results use the ALU's word length and two's-complement convention. A start/busy/done handshake lets the control unit stall until HI/LO are valid.

## Interface
- `WL`, default 32: operand word length in bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WL: multiplicand or dividend; signed for ops 00 and 10.
- `b` in WL: multiplier or divisor.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `hi`, `lo` and `div_by_zero` are valid.
- `hi` out WL: product upper word, or remainder.
- `lo` out WL: product lower word, or quotient.
- `div_by_zero` out 1: last DIV/DIVU had `b`=0.

## Operation
- **States:** IDLE, CALC, FIXUP, DONE.
- **Acceptance:** `start` is accepted in IDLE or DONE. `start` in CALC or FIXUP is ignored.
- **On accept:**
  - Capture the operand magnitudes. Signed ops take absolute values; unsigned ops take raw values.
  - Record the result signs and `op`.
  - Load the iteration counter with WL-1.
  - Next state is CALC, except DIV/DIVU with `b`=0, which goes straight to FIXUP.
- **CALC, multiply:** shift-add, one multiplier bit per cycle, 2·WL-bit accumulator.
- **CALC, divide:** restoring shift-subtract, one quotient bit per cycle.
- **CALC exit:** after exactly WL iterations, go to FIXUP.
- **FIXUP:** apply signs, then write `hi`/`lo` and `div_by_zero`.
  - MULT: negate the 2·WL-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign (truncating division).
  - Divide by zero: `hi`=`a` (raw), `lo`=all ones, `div_by_zero`=1. Any other op clears `div_by_zero`.
  - DIV of −2^(WL−1) by −1: `lo`=0x80000000, `hi`=0, no flag.
- **Result hold:** `hi`/`lo`/`div_by_zero` hold until the next FIXUP.
- **DONE:** lasts one cycle, then IDLE, unless `start` is accepted there.
- **Arithmetic:** internal magnitudes are WL-bit unsigned. Divide partial remainder is WL+1 bits. Counter width is $clog2(WL).

## Timing
- Reset (asynchronous, any state): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter=0. Reset mid-operation aborts it with no `done`.
- `start` accepted at edge T:
  - `busy`=1 from T through edge T+WL+1.
  - At edge T+WL+1, `hi`/`lo` update and `done`=1 for one cycle; `busy`=0 in that cycle.
  - Latency is WL+1 cycles, i.e. 33 at WL=32.
- Divide by zero: FIXUP at T+1, `done`/results at edge T+2.
- Back-to-back: `start` high during the `done` cycle is accepted, with the same timing from that edge. `done` then drops, `busy` rises, and the previous `hi`/`lo` hold until the new FIXUP.
- `op`, `a` and `b` may change freely after the accepting edge.

## Structure
- **Package `muldiv_pkg`:**
  - `op` encoding constants MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State typedef `md_state_t`.
  - Default `WL`.
- **Sub-module `muldiv_addsub`:** combinational WL+1-bit add/subtract with carry/borrow out, shared by the multiply and divide iterations.
- FSM, counter, shift registers and sign fixup live in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, start at edge T -> `busy` through T+32; at edge T+33 `done`=1, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT −3×5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; then DIV −7÷2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `div_by_zero`=0.
- DIVU 100÷0 -> `done` at edge T+2, `hi`=0x00000064, `lo`=0xFFFFFFFF, `div_by_zero`=1; a following MULTU 2×3 clears the flag, `lo`=6, `hi`=0.
- DIV 0x80000000÷0xFFFFFFFF -> `lo`=0x80000000, `hi`=0; DIVU 0xFFFFFFFF÷0x10 -> `lo`=0x0FFFFFFF, `hi`=0xF.
- `start` pulsed with new operands at T+5 while busy -> ignored, first result unchanged. `start` held during the `done` cycle -> second op accepted, its `done` 33 cycles later.
- `rst` asserted at T+10 mid-DIV -> all outputs 0 immediately, state IDLE, no `done`; next `start` after release behaves normally.
